// File: rtl/ast_fifo_source_if.sv
// Avalon-ST link between ast_fifo_source (master) and its sink (slave).
interface ast_fifo_source_if #(
  parameter int WIDTH   = 32,
  parameter int EMPTY_W = 2
);
  logic               ast_ready_i;
  logic               ast_valid_o;
  logic [WIDTH-1:0]   ast_data_o;
  logic               ast_startofpacket_o;
  logic               ast_endofpacket_o;
  logic [EMPTY_W-1:0] ast_empty_o;

  modport master (
    input  ast_ready_i,
    output ast_valid_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o
  );

  modport slave (
    output ast_ready_i,
    input  ast_valid_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o
  );
endinterface

// File: rtl/ast_fifo_source.sv
// Avalon-ST packet source: prefetches FIFO words into a 2-entry buffer and frames
// them with SOP/EOP/empty, honouring the link's readyLatency.
module ast_fifo_source #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int EMPTY_W             = $clog2(SYMBOLS_PER_BEAT),
  parameter int READY_LATENCY       = 2,
  parameter int LEN_W               = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pkt_start_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  output logic                 busy_o,
  output logic                 pkt_done_o,
  output logic                 fifo_rd_o,
  input  logic [WIDTH-1:0]     fifo_data_i,
  input  logic                 fifo_non_empty_i,
  ast_fifo_source_if.master    ast
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   fetch_cnt_q, send_cnt_q, nb_q, nb_in;
  logic [LEN_W:0]     len_round;
  logic [EMPTY_W-1:0] eop_empty_q, empty_in;
  logic [WIDTH-1:0]   buf_q [2];
  logic               wr_ptr_q, rd_ptr_q, rd_pend_q;
  logic [1:0]         occ_q;
  logic               start_ok, rd_acc, pop, eop_xfer, head_avail, sop_cur, eop_cur;
  logic [WIDTH-1:0]   head;
  logic               valid_w, sop_w, eop_w;
  logic [WIDTH-1:0]   data_w;
  logic [EMPTY_W-1:0] empty_w;

  assign len_round = {1'b0, pkt_len_i} + (LEN_W+1)'(SYMBOLS_PER_BEAT - 1);
  assign nb_in     = LEN_W'(len_round >> EMPTY_W);
  assign empty_in  = EMPTY_W'(LEN_W'(0) - pkt_len_i);
  assign start_ok  = (state_q == S_IDLE) && pkt_start_i && (pkt_len_i != '0);

  assign fifo_rd_o = (state_q == S_ACTIVE) && (fetch_cnt_q != '0) &&
                     (({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd2);
  assign rd_acc    = fifo_rd_o && fifo_non_empty_i;

  // With the buffer empty, the word arriving from the FIFO this cycle is the head,
  // so a read can stream straight through at one beat per cycle.
  assign head_avail = (occ_q != 2'd0) || rd_pend_q;
  assign head       = (occ_q != 2'd0) ? buf_q[rd_ptr_q] : fifo_data_i;
  assign sop_cur    = (send_cnt_q == nb_q);
  assign eop_cur    = (send_cnt_q == LEN_W'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      rd_pend_q   <= 1'b0;
      fetch_cnt_q <= '0;
      send_cnt_q  <= '0;
      nb_q        <= '0;
      eop_empty_q <= '0;
    end else begin
      rd_pend_q <= rd_acc;
      if (rd_pend_q) begin
        buf_q[wr_ptr_q] <= fifo_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({rd_pend_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (start_ok) begin
        fetch_cnt_q <= nb_in;
        send_cnt_q  <= nb_in;
        nb_q        <= nb_in;
        eop_empty_q <= empty_in;
      end else begin
        if (rd_acc) fetch_cnt_q <= fetch_cnt_q - LEN_W'(1);
        if (pop)    send_cnt_q  <= send_cnt_q - LEN_W'(1);
      end
    end
  end

  if (READY_LATENCY == 0) begin : g_rl0
    assign valid_w  = (state_q == S_ACTIVE) && head_avail;
    assign pop      = valid_w && ast.ast_ready_i;
    assign data_w   = valid_w ? head : '0;
    assign sop_w    = valid_w && sop_cur;
    assign eop_w    = valid_w && eop_cur;
    assign empty_w  = (valid_w && eop_cur) ? eop_empty_q : '0;
    assign eop_xfer = pop && eop_cur;
  end else begin : g_rl_reg
    logic               allowed_next;
    logic               valid_q, sop_q, eop_q;
    logic [WIDTH-1:0]   data_q;
    logic [EMPTY_W-1:0] empty_q;

    // The output register supplies the last stage of ready delay, so only
    // READY_LATENCY-1 history bits are needed to know if the next cycle is allowed.
    if (READY_LATENCY == 1) begin : g_hist1
      assign allowed_next = ast.ast_ready_i;
    end else begin : g_histn
      logic [READY_LATENCY-2:0] rdy_hist_q;
      logic [READY_LATENCY-1:0] rdy_line;
      assign rdy_line     = {rdy_hist_q, ast.ast_ready_i};
      assign allowed_next = rdy_line[READY_LATENCY-1];
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rdy_hist_q <= '0;
        else        rdy_hist_q <= rdy_line[READY_LATENCY-2:0];
      end
    end

    assign pop = (state_q == S_ACTIVE) && head_avail && allowed_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
        data_q  <= '0;
        empty_q <= '0;
      end else begin
        valid_q <= pop;
        sop_q   <= pop && sop_cur;
        eop_q   <= pop && eop_cur;
        empty_q <= (pop && eop_cur) ? eop_empty_q : '0;
        if (pop) data_q <= head;
      end
    end

    assign valid_w  = valid_q;
    assign data_w   = data_q;
    assign sop_w    = sop_q;
    assign eop_w    = eop_q;
    assign empty_w  = empty_q;
    assign eop_xfer = valid_q && eop_q;
  end

  assign ast.ast_valid_o         = valid_w;
  assign ast.ast_data_o          = data_w;
  assign ast.ast_startofpacket_o = sop_w;
  assign ast.ast_endofpacket_o   = eop_w;
  assign ast.ast_empty_o         = empty_w;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy_o     = 1'b0;
    pkt_done_o = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_ok) state_d = S_ACTIVE;
      S_ACTIVE: begin
        busy_o = 1'b1;
        if (eop_xfer) state_d = S_DONE;
      end
      S_DONE: begin
        busy_o     = 1'b1;
        pkt_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ast_fifo_source.sv
// Scoreboard bench: one readyLatency=2 and one readyLatency=0 source, each fed by a FIFO model.
module tb_ast_fifo_source;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0, start0 = 1'b0;
  logic [15:0] len2 = '0, len0 = '0;
  logic        busy2, done2, rd2, busy0, done0, rd0;
  logic [31:0] fdata2 = '0, fdata0 = '0;
  logic        ne2 = 1'b0, ne0 = 1'b0;
  logic [31:0] fq2[$], fq0[$];
  int          reads2 = 0, reads0 = 0;
  beat_t       exp2[$], exp0[$];
  int          n_checks = 0, n_fail = 0;

  ast_fifo_source_if #(.WIDTH(32), .EMPTY_W(2)) if2 ();
  ast_fifo_source_if #(.WIDTH(32), .EMPTY_W(2)) if0 ();

  ast_fifo_source #(.READY_LATENCY(2)) u_rl2 (
    .clk_i(clk), .rst_i(rst_n), .pkt_start_i(start2), .pkt_len_i(len2),
    .busy_o(busy2), .pkt_done_o(done2), .fifo_rd_o(rd2), .fifo_data_i(fdata2),
    .fifo_non_empty_i(ne2), .ast(if2)
  );

  ast_fifo_source #(.READY_LATENCY(0)) u_rl0 (
    .clk_i(clk), .rst_i(rst_n), .pkt_start_i(start0), .pkt_len_i(len0),
    .busy_o(busy0), .pkt_done_o(done0), .fifo_rd_o(rd0), .fifo_data_i(fdata0),
    .fifo_non_empty_i(ne0), .ast(if0)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // FIFO models: data one cycle after an accepted read, non-empty flag registered.
  always @(posedge clk) begin
    logic [31:0] w;
    if (rd2 && ne2 && fq2.size() != 0) begin
      w = fq2.pop_front();
      fdata2 <= w;
      reads2++;
    end
    ne2 <= (fq2.size() != 0);
    if (rd0 && ne0 && fq0.size() != 0) begin
      w = fq0.pop_front();
      fdata0 <= w;
      reads0++;
    end
    ne0 <= (fq0.size() != 0);
  end

  // Monitors
  int          cyc = 0, beats2 = 0, sop_cyc2 = 0, eop_cyc2 = 0, stalls0 = 0;
  logic        r1 = 1'b0, r2 = 1'b0, exp_done2 = 1'b0, exp_done0 = 1'b0, hold0 = 1'b0;
  logic [31:0] held_data = '0;
  logic [3:0]  held_frame = '0;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (!rst_n) begin
      r1 = 1'b0; r2 = 1'b0; exp_done2 = 1'b0; exp_done0 = 1'b0; hold0 = 1'b0;
    end else begin
      if (done2 || exp_done2) chk("rl2_done_pulse", done2, exp_done2);
      exp_done2 = 1'b0;
      if (if2.ast_valid_o) begin
        chk("rl2_valid_allowed", r2, 1);
        chk("rl2_beat_expected", exp2.size() != 0, 1);
        if (exp2.size() != 0) begin
          b = exp2.pop_front();
          chk("rl2_data", if2.ast_data_o, b.data);
          chk("rl2_frame", {if2.ast_startofpacket_o, if2.ast_endofpacket_o, if2.ast_empty_o},
              {b.sop, b.eop, b.empty});
        end
        beats2++;
        if (if2.ast_startofpacket_o) sop_cyc2 = cyc;
        if (if2.ast_endofpacket_o) begin
          eop_cyc2  = cyc;
          exp_done2 = 1'b1;
        end
      end
      r2 = r1;
      r1 = if2.ast_ready_i;

      if (done0 || exp_done0) chk("rl0_done_pulse", done0, exp_done0);
      exp_done0 = 1'b0;
      if (hold0) begin
        chk("rl0_valid_held", if0.ast_valid_o, 1);
        chk("rl0_data_stable", if0.ast_data_o, held_data);
        chk("rl0_frame_stable", {if0.ast_startofpacket_o, if0.ast_endofpacket_o, if0.ast_empty_o},
            held_frame);
      end
      hold0 = 1'b0;
      if (if0.ast_valid_o && if0.ast_ready_i) begin
        chk("rl0_beat_expected", exp0.size() != 0, 1);
        if (exp0.size() != 0) begin
          b = exp0.pop_front();
          chk("rl0_data", if0.ast_data_o, b.data);
          chk("rl0_frame", {if0.ast_startofpacket_o, if0.ast_endofpacket_o, if0.ast_empty_o},
              {b.sop, b.eop, b.empty});
        end
        if (if0.ast_endofpacket_o) exp_done0 = 1'b1;
      end else if (if0.ast_valid_o) begin
        hold0      = 1'b1;
        held_data  = if0.ast_data_o;
        held_frame = {if0.ast_startofpacket_o, if0.ast_endofpacket_o, if0.ast_empty_o};
        stalls0++;
      end
    end
  end

  // Stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect2(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = m;
    exp2.push_back(b);
  endtask

  task automatic expect0(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = m;
    exp0.push_back(b);
  endtask

  task automatic launch2(input logic [15:0] l);
    start2 = 1'b1; len2 = l;
    tick(1);
    start2 = 1'b0;
  endtask

  task automatic wait_done2(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done2) begin seen = 1'b1; break; end
      tick(1);
    end
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_all_beats"}, exp2.size(), 0);
    tick(1);
  endtask

  initial begin
    int base_rd, base_bt, base_st;
    logic seen;
    int pat [6] = '{1, 0, 1, 1, 0, 1};

    if2.ast_ready_i = 1'b1;
    if0.ast_ready_i = 1'b0;
    tick(3);
    chk("reset_outputs_rl2", {busy2, done2, rd2, if2.ast_valid_o, if2.ast_startofpacket_o,
        if2.ast_endofpacket_o, if2.ast_empty_o, if2.ast_data_o}, 0);
    chk("reset_outputs_rl0", {busy0, done0, rd0, if0.ast_valid_o, if0.ast_startofpacket_o,
        if0.ast_endofpacket_o, if0.ast_empty_o, if0.ast_data_o}, 0);
    rst_n = 1'b1;
    tick(3);

    // 16 symbols, 4 words, ready held high
    fq2.push_back(32'hA0A1A2A3); fq2.push_back(32'hB0B1B2B3);
    fq2.push_back(32'hC0C1C2C3); fq2.push_back(32'hD0D1D2D3);
    expect2(32'hA0A1A2A3, 1, 0, 0); expect2(32'hB0B1B2B3, 0, 0, 0);
    expect2(32'hC0C1C2C3, 0, 0, 0); expect2(32'hD0D1D2D3, 0, 1, 0);
    tick(2);
    base_rd = reads2;
    launch2(16);
    wait_done2("t1");
    chk("t1_reads", reads2 - base_rd, 4);
    chk("t1_back_to_back", eop_cyc2 - sop_cyc2, 3);
    chk("t1_busy_cleared", busy2, 0);

    // 10 symbols, 3 beats, ready pattern 1,0,1,1,0,1
    fq2.push_back(32'hE0E1E2E3); fq2.push_back(32'hF0F1F2F3); fq2.push_back(32'h01020304);
    expect2(32'hE0E1E2E3, 1, 0, 0); expect2(32'hF0F1F2F3, 0, 0, 0);
    expect2(32'h01020304, 0, 1, 2);
    tick(2);
    launch2(10);
    for (int i = 0; i < 6; i++) begin
      if2.ast_ready_i = pat[i][0];
      tick(1);
    end
    if2.ast_ready_i = 1'b1;
    wait_done2("t2");

    // readyLatency 0, one beat held under backpressure
    fq0.push_back(32'h11223344);
    expect0(32'h11223344, 1, 1, 0);
    tick(2);
    base_st = stalls0;
    start0 = 1'b1; len0 = 16'd4;
    tick(1);
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if0.ast_valid_o) begin seen = 1'b1; break; end
      tick(1);
    end
    chk("t3_valid_seen", seen, 1);
    tick(3);
    if0.ast_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done0) begin seen = 1'b1; break; end
      tick(1);
    end
    chk("t3_done_seen", seen, 1);
    chk("t3_stall_cycles", stalls0 - base_st, 3);
    chk("t3_all_beats", exp0.size(), 0);
    chk("t3_reads", reads0, 1);

    // 24 symbols with the FIFO running dry after two words
    fq2.push_back(32'h20000000); fq2.push_back(32'h20000001);
    for (int i = 0; i < 6; i++) expect2(32'h20000000 + 32'(i), i == 0, i == 5, 0);
    tick(2);
    base_rd = reads2;
    base_bt = beats2;
    launch2(24);
    tick(13);
    chk("t4_beats_before_refill", beats2 - base_bt, 2);
    chk("t4_reads_before_refill", reads2 - base_rd, 2);
    for (int i = 2; i < 6; i++) fq2.push_back(32'h20000000 + 32'(i));
    wait_done2("t4");
    chk("t4_reads", reads2 - base_rd, 6);

    // ignored starts: zero length in IDLE, any start while ACTIVE
    launch2(0);
    tick(2);
    chk("t5_len0_busy", busy2, 0);
    fq2.push_back(32'h30000000); fq2.push_back(32'h30000001); fq2.push_back(32'h30000002);
    expect2(32'h30000000, 1, 0, 0); expect2(32'h30000001, 0, 1, 0);
    tick(2);
    base_rd = reads2;
    launch2(8);
    chk("t5_busy_active", busy2, 1);
    launch2(4);
    wait_done2("t5");
    chk("t5_reads", reads2 - base_rd, 2);
    tick(2);
    chk("t5_busy_after", busy2, 0);
    expect2(32'h30000002, 1, 1, 1);
    launch2(3);
    wait_done2("t5b");
    chk("t5b_reads", reads2 - base_rd, 3);

    // reset during beat 2 of a 4-beat packet
    fq2.push_back(32'h40000000); fq2.push_back(32'h40000001);
    fq2.push_back(32'h40000002); fq2.push_back(32'h40000003);
    fq2.push_back(32'h50000000); fq2.push_back(32'h50000001);
    expect2(32'h40000000, 1, 0, 0); expect2(32'h40000001, 0, 0, 0);
    expect2(32'h40000002, 0, 0, 0); expect2(32'h40000003, 0, 1, 0);
    tick(2);
    base_rd = reads2;
    base_bt = beats2;
    launch2(16);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beats2 - base_bt == 1) begin seen = 1'b1; break; end
      tick(1);
    end
    chk("t6_first_beat_seen", seen, 1);
    chk("t6_beat2_present", {if2.ast_valid_o, if2.ast_data_o}, {1'b1, 32'h40000001});
    rst_n = 1'b0;
    exp2.delete();
    #1;
    chk("t6_reset_outputs", {busy2, done2, rd2, if2.ast_valid_o, if2.ast_startofpacket_o,
        if2.ast_endofpacket_o, if2.ast_empty_o, if2.ast_data_o}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    expect2(32'h40000003, 1, 0, 0); expect2(32'h50000000, 0, 1, 1);
    launch2(7);
    wait_done2("t6");
    chk("t6_reads", reads2 - base_rd, 5);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ast_fifo_source.md
Name: ast_fifo_source

Overview:
Avalon-ST source that drains a word FIFO read port and transmits packets on an Avalon-ST link with configurable readyLatency. It is the transmit-side counterpart of the ready-latency-aware FIFO: it issues FIFO reads, prefetches words into a 2-entry buffer, and frames them with startofpacket/endofpacket/empty. A packet is launched by a start pulse carrying a length in symbols.

Parameters:
DATABITS_PER_SYMBOL, 8, bits per symbol
SYMBOLS_PER_BEAT, 4, symbols per beat (power of 2, >=2)
WIDTH, DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT, beat width
EMPTY_W, $clog2(SYMBOLS_PER_BEAT), width of ast_empty_o
READY_LATENCY, 2, Avalon-ST readyLatency, legal 0..4
LEN_W, 16, width of packet length in symbols

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
pkt_start_i  in  1  one-cycle launch pulse, sampled only in IDLE
pkt_len_i  in  LEN_W  packet length in symbols, sampled with pkt_start_i
busy_o  out  1  high from accepted start until DONE exits
pkt_done_o  out  1  one-cycle pulse after EOP beat transferred
fifo_rd_o  out  1  FIFO read request
fifo_data_i  in  WIDTH  FIFO read data, valid the cycle after an accepted read
fifo_non_empty_i  in  1  FIFO has data; read accepted iff fifo_rd_o && fifo_non_empty_i
ast_ready_i  in  1  sink ready
ast_valid_o  out  1  beat valid
ast_data_o  out  WIDTH  beat data, first symbol in MSBs, passed unmodified
ast_startofpacket_o  out  1  first beat of packet
ast_endofpacket_o  out  1  last beat of packet
ast_empty_o  out  EMPTY_W  unused symbols on EOP beat, 0 otherwise

Behaviour:
- Reset (rst_i low, async): state IDLE, buffer empty, counters 0, ready history 0; busy_o, pkt_done_o, fifo_rd_o, ast_valid_o, SOP, EOP all 0; ast_data_o 0; ast_empty_o 0.
- Reset mid-packet: packet abandoned, words already read from the FIFO are discarded, unread words stay in the FIFO; no EOP is emitted.
- Beats: NB = ceil(pkt_len/SYMBOLS_PER_BEAT); EOP-beat empty = NB*SYMBOLS_PER_BEAT - pkt_len.
- FSM IDLE -> ACTIVE on pkt_start_i with pkt_len_i != 0. Latch the length, load the fetch counter and send counter with NB, set busy_o.
- pkt_start_i with length 0 is ignored: no busy, no done pulse.
- pkt_start_i in ACTIVE or DONE is ignored.
- ACTIVE -> DONE on the cycle the EOP beat transfers. DONE lasts 1 cycle with pkt_done_o=1, then returns to IDLE with busy_o=0.
- Fetch rule: fifo_rd_o = ACTIVE && fetch_cnt>0 && (buffer occupancy + reads in flight) < 2. An accepted read decrements fetch_cnt and writes fifo_data_i into the buffer the next cycle. The FIFO is never read beyond NB words.
- Ready-latency rule: a transfer occurs in cycle t iff ast_valid_o(t) && ast_ready_i(t-READY_LATENCY). ast_valid_o is asserted only in such "allowed" cycles, and never in any other cycle.
- READY_LATENCY>=1: keep an RL-deep shift register of ast_ready_i. Outputs are registered. At the edge starting cycle t, load the buffer head into the outputs iff allowed(t) && buffer non-empty; otherwise drive ast_valid_o=0.
- READY_LATENCY=0: valid/data are driven combinationally from the buffer head. The transfer is valid && ready, standard backpressure, and data is held stable while valid && !ready.
- SOP is high on the beat where send_cnt==NB. EOP is high on the beat where send_cnt==1, and ast_empty_o is applied only on that beat. send_cnt decrements per transfer.
- Single-beat packet: SOP and EOP are both set on the same beat.
- A buffer write and a buffer pop in the same cycle are both honoured; occupancy is unchanged.
- Empty FIFO stalls fetch and drops valid in allowed cycles (gap). There is no timeout.

Test Plan:
- RL=2, pkt_len=16, FIFO preloaded 4 words A..D, ready held 1 -> 4 consecutive beats A..D. SOP on A, EOP on D, empty=0. pkt_done_o pulses 1 cycle after D. Exactly 4 FIFO reads.
- RL=2, pkt_len=10 (3 beats), ready pattern 1,0,1,1,0,1 -> valid only 2 cycles after each ready=1. EOP beat has empty=2. No beat in cycles with ready(t-2)=0.
- RL=0, pkt_len=4, ready low for 3 cycles while valid -> data/SOP/EOP held stable. Transfer on first ready=1. empty=0, SOP=EOP=1.
- FIFO empty for 5 cycles mid-packet (pkt_len=24) -> fifo_rd_o gated, valid gaps, beats resume in order. Total reads = 6.
- pkt_start_i pulsed during ACTIVE and with len 0 in IDLE -> both ignored, busy/done unaffected.
- rst_i low during beat 2 of a 4-beat packet -> all outputs 0 immediately. The next packet starts with SOP on the next FIFO word.
